// File: rtl/i2c_status_reg.sv
// i2c_status_reg: registered I2C status with sticky errors, edge interrupts and drop counters
module i2c_status_reg #(
    parameter int               WIDTH         = 13,
    parameter logic [WIDTH-1:0] STICKY_MASK   = 'h1200,
    parameter bit               CLEAR_ON_READ = 1'b0,
    parameter int               CNT_WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     next_status,
    input  logic                 status_rd,
    input  logic                 clr_wr,
    input  logic [WIDTH-1:0]     clr_data,
    input  logic                 ie_wr,
    input  logic [WIDTH-1:0]     ie_data,
    input  logic                 cnt_clr,
    output logic [WIDTH-1:0]     status,
    output logic [WIDTH-1:0]     int_pending,
    output logic [WIDTH-1:0]     int_enable,
    output logic                 irq,
    output logic [CNT_WIDTH-1:0] ovf_count,
    output logic [CNT_WIDTH-1:0] unf_count
);
    localparam int RX_OVF = 9;
    localparam int TX_UNF = 12;

    logic [WIDTH-1:0]     status_d, status_q, prev_d, prev_q, pend_d, pend_q, ie_d, ie_q;
    logic [WIDTH-1:0]     w1c, clr, rise;
    logic [CNT_WIDTH-1:0] ovf_d, ovf_q, unf_d, unf_q;

    // A clear that coincides with an increment still counts that cycle
    function automatic logic [CNT_WIDTH-1:0] cnt_next(input logic [CNT_WIDTH-1:0] c,
                                                      input logic inc, input logic zero);
        return zero ? CNT_WIDTH'(inc) : (inc && c != '1) ? c + 1'b1 : c;
    endfunction

    always_comb begin
        w1c      = clr_wr ? clr_data : '0;
        clr      = w1c | {WIDTH{CLEAR_ON_READ & status_rd}};
        rise     = next_status & ~prev_q;
        prev_d   = next_status;
        status_d = next_status | (STICKY_MASK & status_q & ~clr);
        pend_d   = (rise & ie_q) | (pend_q & ~w1c);
        ie_d     = ie_wr ? ie_data : ie_q;
        ovf_d    = cnt_next(ovf_q, next_status[RX_OVF], cnt_clr);
        unf_d    = cnt_next(unf_q, next_status[TX_UNF], cnt_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q <= '0;
            prev_q   <= '0;
            pend_q   <= '0;
            ie_q     <= '0;
            ovf_q    <= '0;
            unf_q    <= '0;
        end else begin
            status_q <= status_d;
            prev_q   <= prev_d;
            pend_q   <= pend_d;
            ie_q     <= ie_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign status      = status_q;
    assign int_pending = pend_q;
    assign int_enable  = ie_q;
    assign irq         = |(pend_q & ie_q);
    assign ovf_count   = ovf_q;
    assign unf_count   = unf_q;
endmodule

// File: tb/tb_i2c_status_reg.sv
// tb_i2c_status_reg: directed table, corner sequences and random run against a per-bit reference model
module tb_i2c_status_reg;
    logic        clk = 1'b0, rst = 1'b1;
    logic [12:0] ns = '0, clr_data = '0, ie_data = '0;
    logic        rd = 1'b0, clr_wr = 1'b0, ie_wr = 1'b0, cnt_clr = 1'b0;
    logic [12:0] st0, pd0, ie0, st1, pd1, ie1;
    logic        irq0, irq1;
    logic [7:0]  ov0, un0, ov1, un1;
    int          n_pass = 0, n_total = 0;

    logic [12:0] m_st[2], m_pd[2], m_ie[2], m_prev[2];
    int          m_ov[2], m_un[2];

    i2c_status_reg dut0 (.clk(clk), .rst(rst), .next_status(ns), .status_rd(rd), .clr_wr(clr_wr),
        .clr_data(clr_data), .ie_wr(ie_wr), .ie_data(ie_data), .cnt_clr(cnt_clr), .status(st0),
        .int_pending(pd0), .int_enable(ie0), .irq(irq0), .ovf_count(ov0), .unf_count(un0));

    i2c_status_reg #(.CLEAR_ON_READ(1'b1)) dut1 (.clk(clk), .rst(rst), .next_status(ns),
        .status_rd(rd), .clr_wr(clr_wr), .clr_data(clr_data), .ie_wr(ie_wr), .ie_data(ie_data),
        .cnt_clr(cnt_clr), .status(st1), .int_pending(pd1), .int_enable(ie1), .irq(irq1),
        .ovf_count(ov1), .unf_count(un1));

    always #5 clk = ~clk;

    typedef struct {
        logic [12:0] ns;
        logic        rd, clr_wr;
        logic [12:0] clr_data;
        logic        ie_wr;
        logic [12:0] ie_data;
        logic        cnt_clr;
        logic [12:0] exp_st, exp_pd;
        logic        exp_irq;
        int          exp_ov;
    } vec_t;
    vec_t tv[10];

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = '0; m_pd[k] = '0; m_ie[k] = '0; m_prev[k] = '0; m_ov[k] = 0; m_un[k] = 0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 13; i++) begin
                bit sticky = (i == 9) || (i == 12);
                bit wclr   = clr_wr && clr_data[i];
                if (!sticky) m_st[k][i] = ns[i];
                else if (ns[i]) m_st[k][i] = 1'b1;
                else if (wclr || (k == 1 && rd)) m_st[k][i] = 1'b0;
                if (ns[i] && !m_prev[k][i] && m_ie[k][i]) m_pd[k][i] = 1'b1;
                else if (wclr) m_pd[k][i] = 1'b0;
            end
            if (ie_wr) m_ie[k] = ie_data;
            m_prev[k] = ns;
            m_ov[k] = cnt_clr ? int'(ns[9])  : ns[9]  ? ((m_ov[k] < 255) ? m_ov[k] + 1 : 255) : m_ov[k];
            m_un[k] = cnt_clr ? int'(ns[12]) : ns[12] ? ((m_un[k] < 255) ? m_un[k] + 1 : 255) : m_un[k];
        end
    endtask

    task automatic check_model();
        chk("status0", st0, m_st[0]);  chk("pending0", pd0, m_pd[0]); chk("enable0", ie0, m_ie[0]);
        chk("irq0", irq0, int'(|(m_pd[0] & m_ie[0])));
        chk("ovf0", ov0, m_ov[0]);     chk("unf0", un0, m_un[0]);
        chk("status1", st1, m_st[1]);  chk("pending1", pd1, m_pd[1]); chk("enable1", ie1, m_ie[1]);
        chk("irq1", irq1, int'(|(m_pd[1] & m_ie[1])));
        chk("ovf1", ov1, m_ov[1]);     chk("unf1", un1, m_un[1]);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic quiet();
        rd = 0; clr_wr = 0; clr_data = '0; ie_wr = 0; ie_data = '0; cnt_clr = 0;
    endtask

    initial begin
        tv[0] = '{13'h0480, 0, 0, 13'h0000, 0, 13'h0000, 0, 13'h0480, 13'h0000, 0, 0};
        tv[1] = '{13'h0480, 0, 0, 13'h0000, 1, 13'h0200, 0, 13'h0480, 13'h0000, 0, 0};
        tv[2] = '{13'h0680, 0, 0, 13'h0000, 0, 13'h0000, 0, 13'h0680, 13'h0200, 1, 1};
        tv[3] = '{13'h0680, 0, 0, 13'h0000, 0, 13'h0000, 0, 13'h0680, 13'h0200, 1, 2};
        tv[4] = '{13'h0680, 0, 0, 13'h0000, 0, 13'h0000, 0, 13'h0680, 13'h0200, 1, 3};
        tv[5] = '{13'h0480, 0, 0, 13'h0000, 0, 13'h0000, 0, 13'h0680, 13'h0200, 1, 3};
        tv[6] = '{13'h0680, 0, 1, 13'h0200, 0, 13'h0000, 0, 13'h0680, 13'h0200, 1, 4};
        tv[7] = '{13'h0480, 0, 1, 13'h0200, 0, 13'h0000, 0, 13'h0480, 13'h0000, 0, 4};
        tv[8] = '{13'h0480, 0, 1, 13'h1fff, 0, 13'h0000, 0, 13'h0480, 13'h0000, 0, 4};
        tv[9] = '{13'h0480, 0, 0, 13'h0000, 1, 13'h0000, 0, 13'h0480, 13'h0000, 0, 4};

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_model();
        rst = 0;

        foreach (tv[j]) begin
            ns = tv[j].ns; rd = tv[j].rd; clr_wr = tv[j].clr_wr; clr_data = tv[j].clr_data;
            ie_wr = tv[j].ie_wr; ie_data = tv[j].ie_data; cnt_clr = tv[j].cnt_clr;
            cyc();
            chk("tbl_status", st0, tv[j].exp_st);
            chk("tbl_pending", pd0, tv[j].exp_pd);
            chk("tbl_irq", irq0, tv[j].exp_irq);
            chk("tbl_ovf", ov0, tv[j].exp_ov);
        end
        quiet();

        // underflow counter saturates, then clear coinciding with an increment loads 1
        ns = 13'h1000;
        repeat (300) cyc();
        chk("unf_sat", un0, 255);
        cnt_clr = 1;
        cyc();
        chk("unf_clr_inc", un0, 1);
        chk("ovf_clr", ov0, 0);
        cnt_clr = 0;

        ns = '0; ie_wr = 1; ie_data = 13'h0200;
        cyc();
        ie_wr = 0; ns = 13'h0200;
        cyc();
        chk("pend_set", int'(pd0[9]), 1);
        chk("irq_set", irq0, 1);
        ns = '0; ie_wr = 1; ie_data = '0;
        cyc();
        chk("pend_kept_disabled", int'(pd0[9]), 1);
        chk("irq_masked", irq0, 0);
        ie_data = 13'h0200;
        cyc();
        chk("irq_reenabled", irq0, 1);
        ns = 13'h0020; ie_data = 13'h0220;
        cyc();
        chk("pend_old_enable", int'(pd0[5]), 0);
        ie_wr = 0; ns = '0;
        cyc();

        ns = 13'h1000;
        cyc();
        ns = 13'h0800; rd = 1;
        cyc();
        chk("cor_sticky_clr", int'(st1[12]), 0);
        chk("cor_level_kept", int'(st1[11]), 1);
        chk("nocor_sticky_kept", int'(st0[12]), 1);
        rd = 0;

        ns = 13'h1200; ie_wr = 1; ie_data = 13'h1200;
        cyc();
        ie_wr = 0; ns = 13'h0000;
        cyc();
        ns = 13'h1200;
        repeat (3) cyc();
        @(posedge clk);
        model_step();
        #3 rst = 1;
        #1;
        chk("arst_status", st0, 0);    chk("arst_pending", pd0, 0); chk("arst_enable", ie0, 0);
        chk("arst_irq", irq0, 0);      chk("arst_ovf", ov0, 0);     chk("arst_unf", un0, 0);
        chk("arst_status1", st1, 0);   chk("arst_irq1", irq1, 0);
        model_reset();
        @(posedge clk);
        #1;
        check_model();
        rst = 0;
        cyc();
        chk("post_rst_status", st0, 13'h1200);
        chk("post_rst_no_pend", pd0, 0);

        for (int c = 0; c < 400; c++) begin
            ns       = 13'($urandom);
            rd       = ($urandom_range(0, 3) == 0);
            clr_wr   = ($urandom_range(0, 3) == 0);
            clr_data = 13'($urandom);
            ie_wr    = ($urandom_range(0, 7) == 0);
            ie_data  = 13'($urandom);
            cnt_clr  = ($urandom_range(0, 15) == 0);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/i2c_status_reg.md
Name: i2c_status_reg

Overview:
- Registered status/interrupt stage directly downstream of the I2C combinational status logic.
- Captures the 13-bit next-status vector every cycle and holds the error bits sticky.
- Detects rising edges for per-bit interrupt pending flags, drives a single irq line, and keeps saturating drop counters for RX overflow and TX underflow.
- Presents status, pending, enable and counters to the bus register file for software.

Parameters:
- WIDTH, 13, status vector width. Bit map is fixed: [12] tx_underflow, [11] tx_full, [10] tx_empty, [9] rx_overflow, [8] rx_full, [7] rx_empty, [6] mid_tx_empty, [5] mid_rx_full, [4:0] i2c_status.
- STICKY_MASK, 13'h1200, a 1 marks a sticky bit. Default makes bits 12 and 9 sticky.
- CLEAR_ON_READ, 0, when 1, status_rd also clears sticky bits.
- CNT_WIDTH, 8, width of each drop counter.

Ports:
- clk  in  1  system clock, all flops rising-edge.
- rst  in  1  asynchronous active-high reset.
- next_status  in  WIDTH  combinational status vector from the upstream status logic.
- status_rd  in  1  one-cycle strobe, software read of status.
- clr_wr  in  1  one-cycle strobe, write-1-to-clear access.
- clr_data  in  WIDTH  W1C mask for sticky status bits and pending bits.
- ie_wr  in  1  one-cycle strobe, interrupt-enable write.
- ie_data  in  WIDTH  new interrupt-enable value.
- cnt_clr  in  1  one-cycle strobe, zero both counters.
- status  out  WIDTH  registered status.
- int_pending  out  WIDTH  per-bit rising-edge pending flags.
- int_enable  out  WIDTH  interrupt enable register.
- irq  out  1  interrupt request.
- ovf_count  out  CNT_WIDTH  rx_overflow cycles, saturating.
- unf_count  out  CNT_WIDTH  tx_underflow cycles, saturating.

Behaviour:
- Reset: asynchronous. All outputs go to 0 on assertion and stay 0 while rst is high: status, int_pending, int_enable, irq, both counters, and the internal prev_status register.
- Level bits (STICKY_MASK[i]=0): status[i] <= next_status[i] every cycle. Latency is 1 cycle. No clear has any effect.
- Sticky bits (STICKY_MASK[i]=1):
  - Set: next_status[i]=1.
  - Clear: (clr_wr & clr_data[i]), or (CLEAR_ON_READ & status_rd).
  - Set and clear in the same cycle: set wins, bit stays 1.
  - Neither: hold.
- Edge detect: prev_status <= next_status every cycle. rise[i] = next_status[i] & ~prev_status[i].
- Pending bits:
  - int_pending[i] sets on rise[i] & int_enable[i].
  - Clears on clr_wr & clr_data[i]. Set wins over clear in the same cycle.
  - Pending is never set for a disabled bit.
  - Disabling a bit after it is pending leaves it pending.
- Enable register: int_enable <= ie_data on ie_wr. Otherwise it holds.
- irq = OR of (int_pending & int_enable), decoded from flops. irq asserts 1 cycle after the rising edge on next_status.
  - Re-enabling a bit that is still pending re-asserts irq.
- Counters:
  - ovf_count increments on every cycle with next_status[9]=1. unf_count does the same for next_status[12].
  - Each counter saturates at all-ones and never wraps.
  - cnt_clr loads 0. If an increment coincides with cnt_clr, the counter loads 1.
- Simultaneous accesses: clr_wr, ie_wr, status_rd and cnt_clr may all be active in one cycle; each applies independently as above.
  - A pending set that coincides with ie_wr uses the old int_enable value.
- Reset mid-operation clears everything. After release, a bit already high in next_status registers as a rise, because prev_status=0. It only pends if it is enabled by then.

Test Plan:
- Reset then idle with next_status=13'h0480 (tx_empty, rx_empty) -> status=13'h0480 one cycle later; int_pending=0, irq=0, counters=0.
- Enable bit 9, pulse next_status[9] for 3 cycles, then drop it -> status[9] stays 1 after the drop; int_pending[9]=1; irq=1 one cycle after the first assertion; ovf_count=3.
- clr_wr with clr_data=13'h0200 on the same cycle next_status[9]=1 -> status[9] stays 1. Repeat with next_status[9]=0 -> status[9]=0, int_pending[9]=0, irq=0.
- Hold next_status[12]=1 for 300 cycles with CNT_WIDTH=8 -> unf_count=255 and does not wrap. cnt_clr while still asserted -> unf_count=1.
- CLEAR_ON_READ=1: set sticky bit 12, pulse status_rd with next_status[12]=0 -> status[12]=0. Level bit 11 is unaffected by the read.
- Assert rst mid-burst with pending and counters nonzero -> all outputs 0 immediately, without a clock edge.
